// File: rtl/stall_pkg.sv
// stall_pkg -- shared definitions for the pipeline stall controller.
//
// Holds the controller state encoding and the widths used by the
// controller and its performance counter. Imported by stall_controller
// and stall_perf_cnt.
package stall_pkg;

    localparam int CTRL_STATE_W = 2;   // width of the exported ctrl_state
    localparam int FLUSH_CNT_W  = 4;   // flush-cycle counter width
    localparam int CNT_W        = 32;  // performance counter width

    typedef enum logic [CTRL_STATE_W-1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/stall_perf_cnt.sv
// stall_perf_cnt -- saturating up-counter counting stalled cycles.
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-high reset, clears the count
//   inc         count this cycle (registered stall from the controller)
//   load        load load_value into the counter (takes priority over inc)
//   load_value  value to load
//   count       current count; holds at all-ones instead of wrapping
module stall_perf_cnt
    import stall_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/stall_controller.sv
// stall_controller -- global stall/flush sequencer for a set of buffers.
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-high reset
//   ext_stall     downstream not ready (level)
//   flush_req     single-cycle flush request
//   buf_full      per-buffer full flags   [NUM_BUF-1:0]
//   buf_empty     per-buffer empty flags  [NUM_BUF-1:0]
//   stall         registered global stall
//   flush         registered global flush
//   src_hold      registered stop-issue to the pipeline source
//   ctrl_state    current state (RUN=0, STALL=1, DRAIN=2, FLUSH=3)
//   stall_cycles  stalled-cycle count; 0 unless STALL_CNT_EN is defined
//
// Build option: define STALL_CNT_EN to instantiate the saturating stall
// cycle counter (stall_perf_cnt). Without it stall_cycles is tied to 0.
module stall_controller
    import stall_pkg::*;
#(
    parameter int NUM_BUF      = 4,
    parameter int FLUSH_CYCLES = 2   // legal range 1..15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ext_stall,
    input  logic                    flush_req,
    input  logic [NUM_BUF-1:0]      buf_full,
    input  logic [NUM_BUF-1:0]      buf_empty,
    output logic                    stall,
    output logic                    flush,
    output logic                    src_hold,
    output logic [CTRL_STATE_W-1:0] ctrl_state,
    output logic [CNT_W-1:0]        stall_cycles
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_t             state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                    src_hold_d;
    logic                    hold_clear;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;

        // flush_req outranks ext_stall everywhere, and restarts an ongoing flush.
        if (flush_req) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ext_stall) state_d = STALL;
                end
                STALL: begin
                    if (!ext_stall) state_d = DRAIN;
                end
                DRAIN: begin
                    if (ext_stall)       state_d = STALL;
                    else if (&buf_empty) state_d = RUN;
                end
                FLUSH: begin
                    // ext_stall is deliberately not looked at while flushing.
                    if (flush_cnt_q == '0) state_d = RUN;
                    else                   flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
                end
                default: state_d = RUN;
            endcase
        end
    end

    // src_hold drops only when the FSM re-enters RUN after draining or
    // flushing; a full buffer in the same cycle wins and keeps it set.
    // A full buffer never forces STALL on its own: the source is held
    // instead, so the buffers can still drain.
    assign hold_clear = ((state_q == DRAIN) || (state_q == FLUSH)) && (state_d == RUN);
    assign src_hold_d = (|buf_full) || (src_hold && !hold_clear);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            stall       <= 1'b0;
            flush       <= 1'b0;
            src_hold    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            // Outputs come from their own flops, decoded from the next state,
            // so they change on the same edge as ctrl_state.
            stall       <= (state_d == STALL);
            flush       <= (state_d == FLUSH);
            src_hold    <= src_hold_d;
        end
    end

    assign ctrl_state = state_q;

`ifdef STALL_CNT_EN
    stall_perf_cnt u_perf_cnt (
        .clk        (clk),
        .reset      (reset),
        .inc        (stall),
        .load       (1'b0),
        .load_value ({CNT_W{1'b0}}),
        .count      (stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_stall_controller.sv
// tb_stall_controller -- directed bench for stall_controller.
//
// A cycle-level model tracks mode, remaining flush cycles, the hold flag
// and the stall count from the behavioural rules; a compare process checks
// every DUT output against it on each falling edge. Hand-computed literal
// expectations along the stimulus sequence pin the model itself.
module tb_stall_controller;
    import stall_pkg::*;

    localparam int NB = 4;
    localparam int FC = 2;

    localparam int M_RUN   = 0;
    localparam int M_STALL = 1;
    localparam int M_DRAIN = 2;
    localparam int M_FLUSH = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              ext_stall;
    logic              flush_req;
    logic [NB-1:0]     buf_full;
    logic [NB-1:0]     buf_empty;
    logic              stall;
    logic              flush;
    logic              src_hold;
    logic [1:0]        ctrl_state;
    logic [31:0]       stall_cycles;

    always #5 clk = ~clk;

    stall_controller #(
        .NUM_BUF      (NB),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_stall    (ext_stall),
        .flush_req    (flush_req),
        .buf_full     (buf_full),
        .buf_empty    (buf_empty),
        .stall        (stall),
        .flush        (flush),
        .src_hold     (src_hold),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles)
    );

`ifdef STALL_CNT_EN
    logic        sat_inc  = 1'b0;
    logic        sat_load = 1'b0;
    logic [31:0] sat_val  = '0;
    logic [31:0] sat_count;

    stall_perf_cnt u_sat (
        .clk        (clk),
        .reset      (reset),
        .inc        (sat_inc),
        .load       (sat_load),
        .load_value (sat_val),
        .count      (sat_count)
    );
`endif

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model state.
    int              m_mode       = M_RUN;
    int              m_flush_left = 0;   // flush cycles still to be shown
    bit              m_hold       = 1'b0;
    longint unsigned m_cnt        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_step();
        int prev;
        if (reset) begin
            m_mode       = M_RUN;
            m_flush_left = 0;
            m_hold       = 1'b0;
            m_cnt        = 0;
        end else begin
`ifdef STALL_CNT_EN
            if (m_mode == M_STALL && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
`endif
            prev = m_mode;
            if (flush_req) begin
                m_mode       = M_FLUSH;
                m_flush_left = FC;
            end else if (m_mode == M_RUN) begin
                if (ext_stall) m_mode = M_STALL;
            end else if (m_mode == M_STALL) begin
                if (!ext_stall) m_mode = M_DRAIN;
            end else if (m_mode == M_DRAIN) begin
                if (ext_stall)                m_mode = M_STALL;
                else if (buf_empty == 4'hF)   m_mode = M_RUN;
            end else begin
                m_flush_left--;
                if (m_flush_left == 0) m_mode = M_RUN;
            end
            if (buf_full != 4'h0)
                m_hold = 1'b1;
            else if ((prev == M_DRAIN || prev == M_FLUSH) && m_mode == M_RUN)
                m_hold = 1'b0;
        end
    endtask

    // One clock: apply inputs, step the model on the rising edge, return on
    // the falling edge where the outputs are compared.
    task automatic cyc(input logic rst, input logic ext, input logic fr,
                       input logic [NB-1:0] full, input logic [NB-1:0] empty);
        reset     = rst;
        ext_stall = ext;
        flush_req = fr;
        buf_full  = full;
        buf_empty = empty;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int st, input logic s,
                       input logic f, input logic h);
        check({name, ".state"},    32'(ctrl_state), 32'(st));
        check({name, ".stall"},    32'(stall),      32'(s));
        check({name, ".flush"},    32'(flush),      32'(f));
        check({name, ".src_hold"}, 32'(src_hold),   32'(h));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model.state",        32'(ctrl_state), 32'(m_mode));
            check("model.stall",        32'(stall),      32'(m_mode == M_STALL));
            check("model.flush",        32'(flush),      32'(m_mode == M_FLUSH));
            check("model.src_hold",     32'(src_hold),   32'(m_hold));
            check("model.stall_cycles", stall_cycles,    m_cnt[31:0]);
        end
    end

    localparam logic [NB-1:0] Z = 4'b0000;
    localparam logic [NB-1:0] E = 4'b1111;

    initial begin
        cyc(1, 0, 0, Z, E);
        cyc(1, 0, 0, Z, E);
        chk_en = 1'b1;
        lit("reset", 0, 0, 0, 0);
        check("reset.stall_cycles", stall_cycles, 32'd0);

        repeat (4) cyc(0, 0, 0, Z, E);
        lit("idle", 0, 0, 0, 0);

        // Basic stall: three cycles of ext_stall, then DRAIN, then RUN.
        repeat (3) begin
            cyc(0, 1, 0, Z, E);
            lit("basic.stall", 1, 1, 0, 0);
        end
        cyc(0, 0, 0, Z, E);  lit("basic.drain", 2, 0, 0, 0);
        cyc(0, 0, 0, Z, E);  lit("basic.run",   0, 0, 0, 0);

        // Drain hold until every buffer reports empty.
        cyc(0, 1, 0, Z, 4'b1100);  lit("drainhold.stall", 1, 1, 0, 0);
        cyc(0, 0, 0, Z, 4'b1100);  lit("drainhold.d1",    2, 0, 0, 0);
        cyc(0, 0, 0, Z, 4'b1100);  lit("drainhold.d2",    2, 0, 0, 0);
        cyc(0, 0, 0, Z, E);        lit("drainhold.run",   0, 0, 0, 0);

        // Flush beats a simultaneous stall, lasts FC cycles, ignores ext_stall.
        cyc(0, 1, 1, Z, E);  lit("flushprio.f1",  3, 0, 1, 0);
        cyc(0, 1, 0, Z, E);  lit("flushprio.f2",  3, 0, 1, 0);
        cyc(0, 1, 0, Z, E);  lit("flushprio.run", 0, 0, 0, 0);
        cyc(0, 1, 0, Z, E);  lit("flushprio.stall", 1, 1, 0, 0);

        // Full during STALL: hold sets next cycle, clears on RUN entry.
        cyc(0, 1, 0, 4'b0010, E);  lit("full.set",    1, 1, 0, 1);
        cyc(0, 0, 0, Z, 4'b0111);  lit("full.drain1", 2, 0, 0, 1);
        cyc(0, 0, 0, Z, 4'b0111);  lit("full.drain2", 2, 0, 0, 1);
        cyc(0, 0, 0, Z, E);        lit("full.clear",  0, 0, 0, 0);

        // Full alone does not stall; hold persists through RUN.
        cyc(0, 0, 0, E, E);  lit("fullrun.set",  0, 0, 0, 1);
        cyc(0, 0, 0, Z, E);  lit("fullrun.keep", 0, 0, 0, 1);

        // Set and clear in the same cycle: set wins.
        cyc(0, 1, 0, Z, E);        lit("setclr.stall", 1, 1, 0, 1);
        cyc(0, 0, 0, Z, E);        lit("setclr.drain", 2, 0, 0, 1);
        cyc(0, 0, 0, 4'b0100, E);  lit("setclr.run",   0, 0, 0, 1);

        // Flush restart, then hold clears on RUN entry from FLUSH.
        cyc(0, 0, 1, Z, E);  lit("restart.f1",  3, 0, 1, 1);
        cyc(0, 0, 1, Z, E);  lit("restart.f2",  3, 0, 1, 1);
        cyc(0, 0, 0, Z, E);  lit("restart.f3",  3, 0, 1, 1);
        cyc(0, 0, 0, Z, E);  lit("restart.run", 0, 0, 0, 0);

        // Reset on the first FLUSH cycle.
        cyc(0, 0, 1, Z, E);  lit("rstflush.f1",   3, 0, 1, 0);
        cyc(1, 0, 0, Z, E);  lit("rstflush.rst",  0, 0, 0, 0);
        cyc(0, 0, 0, Z, E);  lit("rstflush.after", 0, 0, 0, 0);

        // Reset in the middle of DRAIN with src_hold set.
        cyc(0, 1, 0, 4'b0001, Z);  lit("rstdrain.stall", 1, 1, 0, 1);
        cyc(0, 0, 0, Z, Z);        lit("rstdrain.drain", 2, 0, 0, 1);
        cyc(1, 0, 0, Z, Z);        lit("rstdrain.rst",   0, 0, 0, 0);
        cyc(0, 0, 0, Z, E);        lit("rstdrain.after", 0, 0, 0, 0);

`ifdef STALL_CNT_EN
        // Ten stalled cycles counted; flush does not clear the count.
        cyc(1, 0, 0, Z, E);
        repeat (10) cyc(0, 1, 0, Z, E);
        cyc(0, 0, 0, Z, E);
        check("cnt.ten", stall_cycles, 32'd10);
        cyc(0, 0, 1, Z, E);
        check("cnt.after_flush", stall_cycles, 32'd10);
        cyc(0, 0, 0, Z, E);

        // Saturation of a preloaded counter.
        sat_load = 1'b1;
        sat_val  = 32'hFFFF_FFFD;
        cyc(0, 0, 0, Z, E);
        check("sat.load", sat_count, 32'hFFFF_FFFD);
        sat_load = 1'b0;
        sat_inc  = 1'b1;
        cyc(0, 0, 0, Z, E);  check("sat.fe",    sat_count, 32'hFFFF_FFFE);
        cyc(0, 0, 0, Z, E);  check("sat.ff",    sat_count, 32'hFFFF_FFFF);
        cyc(0, 0, 0, Z, E);  check("sat.hold1", sat_count, 32'hFFFF_FFFF);
        cyc(0, 0, 0, Z, E);  check("sat.hold2", sat_count, 32'hFFFF_FFFF);
        sat_inc = 1'b0;
`else
        // Counter absent: the port reads 0 even after stalling.
        repeat (3) cyc(0, 1, 0, Z, E);
        cyc(0, 0, 0, Z, E);
        check("cnt.off", stall_cycles, 32'd0);
        cyc(0, 0, 0, Z, E);
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
